// File: rtl/ddram_responder.sv
// Block-RAM backed responder for the DDRAM_* Avalon-MM port: bursts, byte enables, fixed read latency.
// Optional macro DDRAM_STALL_EN adds LFSR-driven random BUSY stalls in IDLE and WR_BURST.
module ddram_responder #(
   parameter int         AW     = 12,
   parameter int         RD_LAT = 2,
   parameter logic [3:0] BASE   = 4'b0011
) (
   input  logic        DDRAM_CLK,
   input  logic        reset_n,
   output logic        DDRAM_BUSY,
   input  logic [7:0]  DDRAM_BURSTCNT,
   input  logic [28:0] DDRAM_ADDR,
   output logic [63:0] DDRAM_DOUT,
   output logic        DDRAM_DOUT_READY,
   input  logic        DDRAM_RD,
   input  logic [63:0] DDRAM_DIN,
   input  logic [7:0]  DDRAM_BE,
   input  logic        DDRAM_WE
);

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;

   state_t        state_q;
   logic          busy_q;
   logic          dout_ready_q;
   logic [63:0]   dout_q;
   logic [AW-1:0] ptr_q;
   logic [7:0]    rem_q;
   logic [3:0]    lat_q;
   logic          hit_q;
   logic          issue_v_q;
   logic [63:0]   ram_q;
   logic [63:0]   mem [2**AW];

   logic          addr_hit;
   logic [AW-1:0] addr_idx;
   logic [7:0]    burst_len;
   logic          accept_wr;
   logic          accept_rd;
   logic          stall_d;
   logic          mem_we;
   logic [AW-1:0] mem_idx;
   logic          unused_addr;

   assign addr_hit    = (DDRAM_ADDR[28:25] == BASE);
   assign addr_idx    = DDRAM_ADDR[AW-1:0];
   assign unused_addr = ^DDRAM_ADDR[24:AW];
   assign burst_len   = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
   assign accept_wr   = !busy_q && DDRAM_WE && (state_q == IDLE || state_q == WR_BURST);
   assign accept_rd   = !busy_q && DDRAM_RD && !DDRAM_WE && (state_q == IDLE);

`ifdef DDRAM_STALL_EN
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   // BUSY is registered, so the stall decision tracks the LFSR value it will sit beside.
   assign stall_d = (lfsr_d[1:0] == 2'b00);

   always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
      if (!reset_n) lfsr_q <= 16'hACE1;
      else          lfsr_q <= lfsr_d;
   end
`else
   assign stall_d = 1'b0;
`endif

   // Beat 0 of a write goes straight to RAM; later beats use the running pointer.
   always_comb begin
      mem_we  = 1'b0;
      mem_idx = addr_idx;
      if (accept_wr && state_q == IDLE) begin
         mem_we  = addr_hit;
         mem_idx = addr_idx;
      end else if (accept_wr && state_q == WR_BURST) begin
         mem_we  = hit_q;
         mem_idx = ptr_q;
      end
   end

   always_ff @(posedge DDRAM_CLK) begin
      if (mem_we) begin
         for (int b = 0; b < 8; b++) begin
            if (DDRAM_BE[b]) mem[mem_idx][8*b +: 8] <= DDRAM_DIN[8*b +: 8];
         end
      end
      ram_q <= mem[ptr_q];
   end

   always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         busy_q       <= 1'b1;
         dout_ready_q <= 1'b0;
         dout_q       <= '0;
         ptr_q        <= '0;
         rem_q        <= '0;
         lat_q        <= '0;
         hit_q        <= 1'b0;
         issue_v_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               busy_q <= stall_d;
               if (accept_wr) begin
                  if (burst_len > 8'd1) begin
                     state_q <= WR_BURST;
                     rem_q   <= burst_len - 8'd1;
                     ptr_q   <= addr_idx + 1'b1;
                     hit_q   <= addr_hit;
                  end
               end else if (accept_rd) begin
                  busy_q  <= 1'b1;
                  ptr_q   <= addr_idx;
                  rem_q   <= burst_len;
                  hit_q   <= addr_hit;
                  lat_q   <= 4'(RD_LAT - 1);
                  state_q <= (RD_LAT == 1) ? RD_BURST : RD_WAIT;
               end
            end
            WR_BURST: begin
               busy_q <= stall_d;
               if (accept_wr) begin
                  ptr_q <= ptr_q + 1'b1;
                  rem_q <= rem_q - 8'd1;
                  if (rem_q == 8'd1) state_q <= IDLE;
               end
            end
            RD_WAIT: begin
               lat_q <= lat_q - 4'd1;
               if (lat_q == 4'd1) state_q <= RD_BURST;
            end
            RD_BURST: begin
               // RAM address issue runs one cycle ahead of the DOUT stage.
               if (rem_q != 8'd0) begin
                  ptr_q     <= ptr_q + 1'b1;
                  rem_q     <= rem_q - 8'd1;
                  issue_v_q <= 1'b1;
               end else begin
                  issue_v_q <= 1'b0;
               end
               if (issue_v_q) begin
                  dout_ready_q <= 1'b1;
                  dout_q       <= hit_q ? ram_q : 64'h0;
               end else if (rem_q == 8'd0) begin
                  dout_ready_q <= 1'b0;
                  busy_q       <= stall_d;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign DDRAM_BUSY       = busy_q;
   assign DDRAM_DOUT_READY = dout_ready_q;
   assign DDRAM_DOUT       = dout_q;

endmodule
